// File: rtl/addsub_serial_16bit_pkg.sv
// Purpose : shared types and constants for the serial 16-bit adder/subtractor.
// Contents: FSM state enum, saturation limits, signed-overflow and saturation helpers.
// Used by : addsub_serial_16bit (top), imported with import addsub_pkg::*.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  // Two same-signed operands producing a result of the other sign overflowed.
  function automatic logic signed_ovfl(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // Overflow direction follows the sign of A (both operands share it).
  function automatic logic [15:0] sat_value(input logic a_msb);
    return a_msb ? SAT_NEG : SAT_POS;
  endfunction

endpackage

// File: rtl/addsub_serial_16bit_if.sv
// Purpose : operand/result handshake bundle for addsub_serial_16bit.
// Ports   : in_valid/in_ready + a, b, sub (request); out_valid/out_ready + sum, ovfl (result).
// Modports: slave = the arithmetic block, master = the requester/consumer.
interface addsub_serial_16bit_if;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        ovfl;

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, ovfl
  );

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, ovfl
  );

endinterface

// File: rtl/addsub_serial_16bit_slice.sv
// Purpose : SLICE_W-bit ripple adder slice, purely combinational.
// Latency : 0 cycles; no flow control.
// Ports   : a, b, c_in -> sum, c_out.
module addsub_slice #(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               c_in,
  output logic [SLICE_W-1:0] sum,
  output logic               c_out
);

  logic [SLICE_W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, c_in};
  assign sum   = total[SLICE_W-1:0];
  assign c_out = total[SLICE_W];

endmodule

// File: rtl/addsub_serial_16bit.sv
// Purpose : signed 16-bit A+B / A-B computed SLICE_W bits per cycle with one shared slice adder.
// Latency : accept at edge N -> out_valid after edge N+16/SLICE_W; one operation in flight.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, in_valid ignored meanwhile.
// Ports   : clk, rst_n (sync, active-low), bus (addsub_serial_16bit_if.slave).
// Config  : define ADDSUB_SERIAL_SAT_EN to saturate the sum on overflow; otherwise it wraps.
module addsub_serial_16bit
  import addsub_pkg::*;
#(
  parameter int SLICE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  addsub_serial_16bit_if.slave  bus
);

  localparam int         NSLICE   = 16 / SLICE_W;
  localparam logic [2:0] LAST_IDX = 3'(NSLICE - 1);

  if (!(SLICE_W == 4 || SLICE_W == 8 || SLICE_W == 16)) begin : g_bad_slice_w
    $error("addsub_serial_16bit: SLICE_W must be 4, 8 or 16");
  end

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;        // b already inverted for subtraction
  logic [15:0] raw_q, raw_d;    // slice results accumulated LSB first
  logic [15:0] sum_q, sum_d;
  logic        ovfl_q, ovfl_d;
  logic        carry_q, carry_d;
  logic [2:0]  idx_q, idx_d;

  logic               in_ready;
  logic               out_valid;
  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_sum;
  logic               sl_cout;

  assign sl_a = a_q[idx_q*SLICE_W +: SLICE_W];
  assign sl_b = b_q[idx_q*SLICE_W +: SLICE_W];

  addsub_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a     (sl_a),
    .b     (sl_b),
    .c_in  (carry_q),
    .sum   (sl_sum),
    .c_out (sl_cout)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    raw_d     = raw_q;
    sum_d     = sum_q;
    ovfl_d    = ovfl_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          // Subtraction as A + ~B + 1: the +1 rides in on the first carry.
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          idx_d   = 3'd0;
          raw_d   = 16'h0000;
          state_d = CALC;
        end
      end

      CALC: begin
        raw_d[idx_q*SLICE_W +: SLICE_W] = sl_sum;
        carry_d = sl_cout;
        idx_d   = idx_q + 3'd1;
        if (idx_q == LAST_IDX) begin
          // Final slice: raw_d now holds the full result; carry out of bit 15 is dropped.
          idx_d   = 3'd0;
          carry_d = 1'b0;
          ovfl_d  = signed_ovfl(a_q[15], b_q[15], raw_d[15]);
`ifdef ADDSUB_SERIAL_SAT_EN
          sum_d   = ovfl_d ? sat_value(a_q[15]) : raw_d;
`else
          sum_d   = raw_d;
`endif
          state_d = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      raw_q   <= 16'h0000;
      sum_q   <= 16'h0000;
      ovfl_q  <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      raw_q   <= raw_d;
      sum_q   <= sum_d;
      ovfl_q  <= ovfl_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.sum       = sum_q;
  assign bus.ovfl      = ovfl_q;

endmodule

// File: tb/tb_addsub_serial_16bit.sv
// Purpose : self-checking bench for addsub_serial_16bit at SLICE_W = 4, 8 and 16 in parallel.
// Latency : expects out_valid 16/SLICE_W cycles after accept.
// Backpressure: stalls out_ready in DONE and pulses in_valid while busy.
module tb_addsub_serial_16bit;

`ifdef ADDSUB_SERIAL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv[3];
  logic        sb[3];
  logic        ordy[3];
  logic [15:0] av[3];
  logic [15:0] bv[3];
  logic        ir[3];
  logic        ov[3];
  logic        ovf[3];
  logic [15:0] sm[3];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int SW = (g == 0) ? 4 : ((g == 1) ? 8 : 16);
    addsub_serial_16bit_if bus ();
    assign bus.in_valid  = iv[g];
    assign bus.a         = av[g];
    assign bus.b         = bv[g];
    assign bus.sub       = sb[g];
    assign bus.out_ready = ordy[g];
    assign ir[g]         = bus.in_ready;
    assign ov[g]         = bus.out_valid;
    assign sm[g]         = bus.sum;
    assign ovf[g]        = bus.ovfl;
    addsub_serial_16bit #(.SLICE_W(SW)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  function automatic int sw_of(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 8 : 16);
  endfunction

  // Reference: exact integer arithmetic, overflow = out of the int16 range.
  function automatic logic [16:0] ref_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    int          full;
    logic        o;
    logic [15:0] r;
    full = int'($signed(a)) + (s ? -int'($signed(b)) : int'($signed(b)));
    o    = (full > 32767) || (full < -32768);
    r    = full[15:0];
    if (o && SAT) r = (full > 0) ? 16'h7FFF : 16'h8000;
    return {o, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transaction on DUT d: accept, measure latency, check result,
  // hold out_ready low for `stall` cycles, then handshake.
  task automatic do_op(input int d, input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [15:0] es, input logic eo, input int stall, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready idle"}, 32'(ir[d]), 32'd1);
    iv[d] = 1'b1; av[d] = a; bv[d] = b; sb[d] = s;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs while busy: they must not affect the result.
    iv[d] = 1'b0; av[d] = 16'($urandom); bv[d] = 16'($urandom); sb[d] = 1'($urandom);
    chk({tag, " in_ready busy"}, 32'(ir[d]), 32'd0);
    lat = 0;
    while (!ov[d] && lat < 64) begin
      @(negedge clk);
      lat++;
      iv[d] = 1'($urandom);
    end
    chk({tag, " latency"}, 32'(lat), 32'(16 / sw_of(d)));
    chk({tag, " sum"}, 32'(sm[d]), 32'(es));
    chk({tag, " ovfl"}, 32'(ovf[d]), 32'(eo));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      iv[d] = 1'($urandom); av[d] = 16'($urandom);
      chk({tag, " hold valid"}, 32'(ov[d]), 32'd1);
      chk({tag, " hold sum"}, 32'(sm[d]), 32'(es));
    end
    @(negedge clk);
    ordy[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[d] = 1'b0;
    iv[d]   = 1'b0;
    // in_valid may have been high on the handshake edge; it must not have been taken.
    chk({tag, " post in_ready"}, 32'(ir[d]), 32'd1);
    chk({tag, " post out_valid"}, 32'(ov[d]), 32'd0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] es;
    logic        eo;
  } vec_t;

  vec_t tbl[9];
  logic [16:0] e;

  initial begin
    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    tbl[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b1};
    tbl[3] = '{16'h8000, 16'h0001, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1};
    tbl[4] = '{16'h0000, 16'h8000, 1'b1, SAT ? 16'h7FFF : 16'h8000, 1'b1};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b0};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1};
    tbl[7] = '{16'h7FFF, 16'hFFFF, 1'b1, SAT ? 16'h7FFF : 16'h8000, 1'b1};
    tbl[8] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0};

    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; sb[d] = 1'b0; ordy[d] = 1'b0; av[d] = 16'h0; bv[d] = 16'h0;
    end

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset in_ready", 32'(ir[d]), 32'd1);
      chk("reset out_valid", 32'(ov[d]), 32'd0);
      chk("reset sum", 32'(sm[d]), 32'h0);
      chk("reset ovfl", 32'(ovf[d]), 32'd0);
    end
    rst_n = 1'b1;

    // Fixed vectors on every slice width
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 9; i++)
        do_op(d, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].es, tbl[i].eo, i % 2, "table");

    // Result held for 3 stalled cycles with in_valid pulses, then no stray op
    do_op(0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 3, "stall");
    repeat (6) @(negedge clk);
    chk("stall no stray op", 32'(ov[0]), 32'd0);
    chk("stall idle ready", 32'(ir[0]), 32'd1);

    // Reset during the second CALC cycle aborts the operation
    @(negedge clk);
    iv[0] = 1'b1; av[0] = 16'h1234; bv[0] = 16'h4321; sb[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort in_ready", 32'(ir[0]), 32'd1);
    chk("abort out_valid", 32'(ov[0]), 32'd0);
    chk("abort sum", 32'(sm[0]), 32'h0);
    chk("abort other sum", 32'(sm[1]), 32'h0);
    repeat (6) @(negedge clk);
    chk("abort no result", 32'(ov[0]), 32'd0);
    do_op(0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 0, "after abort");

    // Random operations against the reference model
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 40; i++) begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        ra = 16'($urandom);
        rb = 16'($urandom);
        rs = 1'($urandom);
        if (i % 8 == 0) ra = {ra[15], {15{~ra[15]}}};  // push towards the limits
        e = ref_op(ra, rb, rs);
        do_op(d, ra, rb, rs, e[15:0], e[16], $urandom_range(0, 3), "random");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
